// File: rtl/dnn_train_pkg.sv
// Shared types and helpers for the DNN training-data sequencer.
package dnn_train_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Galois right-shift feedback masks for maximal-length LFSRs, indexed by width.
    function automatic logic [31:0] lfsr_taps(input int w);
        logic [31:0] t;
        case (w)
            1:       t = 32'h0000_0001;
            2:       t = 32'h0000_0003;
            3:       t = 32'h0000_0006;
            4:       t = 32'h0000_000C;
            5:       t = 32'h0000_0014;
            6:       t = 32'h0000_0030;
            7:       t = 32'h0000_0060;
            8:       t = 32'h0000_00B8;
            9:       t = 32'h0000_0110;
            10:      t = 32'h0000_0240;
            11:      t = 32'h0000_0500;
            12:      t = 32'h0000_0E08;
            13:      t = 32'h0000_1C80;
            14:      t = 32'h0000_3802;
            15:      t = 32'h0000_6000;
            16:      t = 32'h0000_D008;
            default: t = 32'h0000_0000;
        endcase
        return t;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/slice_sel.sv
// MSB-first slice selector: slice idx of an N-slice vector, zero when idx >= N or en is low.
module slice_sel #(
    parameter int W    = 4,
    parameter int N    = 16,
    parameter int IDXW = 5
) (
    input  logic [W*N-1:0] vec,
    input  logic [IDXW-1:0] idx,
    input  logic           en,
    output logic [W-1:0]   slice
);

    logic [W-1:0] hit [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slice
            assign hit[gi] = (en && idx == IDXW'(gi)) ? vec[(N-1-gi)*W +: W] : '0;
        end
    endgenerate

    always_comb begin
        slice = '0;
        for (int i = 0; i < N; i++) begin
            slice = slice | hit[i];
        end
    end

endmodule

// File: rtl/dnn_train_sequencer.sv
// Streams stored training cases into the DNN and scores its outputs per case/epoch/run.
// Optional SHUFFLE_EN: case order is the sequential index XORed with a per-epoch LFSR mask.
module dnn_train_sequencer
    import dnn_train_pkg::*;
#(
    parameter int NI        = 64,
    parameter int NO        = 4,
    parameter int A_W       = 4,
    parameter int Y_W       = 1,
    parameter int TC        = 32,
    parameter int CPC       = NI / A_W + 2,
    parameter int CMP_START = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [$clog2(TC)-1:0]  wr_addr,
    input  logic [NI-1:0]          wr_a,
    input  logic [NO-1:0]          wr_y,
    input  logic                   start,
    input  logic [31:0]            max_cases,
    output logic [A_W-1:0]         a_in,
    output logic [Y_W-1:0]         y_in,
    input  logic [Y_W-1:0]         a_out,
    input  logic [Y_W-1:0]         y_out,
    output logic                   running,
    output logic                   done,
    output logic [$clog2(TC)-1:0]  case_idx,
    output logic [$clog2(CPC)-1:0] cycle_idx,
    output logic                   case_done,
    output logic                   case_err,
    output logic [31:0]            case_count,
    output logic [31:0]            err_total,
    output logic                   epoch_done,
    output logic [31:0]            epoch_err
);

    localparam int CW = $clog2(TC);
    localparam int KW = $clog2(CPC);

    logic [NI-1:0] mem_a [TC];
    logic [NO-1:0] mem_y [TC];

    state_t        state_reg, state_next;
    logic [CW-1:0] seq_reg;
    logic [CW-1:0] mask;
    logic [KW-1:0] cycle_reg;
    logic [31:0]   max_reg, count_reg, err_total_reg, epoch_acc_reg, epoch_err_reg;
    logic          flag_reg, case_done_reg, case_err_reg, epoch_done_reg;

    logic          start_go, last_cycle, cmp_hit, case_err_now, last_case, epoch_wrap;
    logic [CW-1:0] rd_idx;

    assign start_go     = start && (state_reg != RUN);
    assign last_cycle   = (state_reg == RUN) && (cycle_reg == KW'(CPC - 1));
    assign cmp_hit      = (state_reg == RUN) && (cycle_reg >= KW'(CMP_START)) && (a_out != y_out);
    // A mismatch seen in the final cycle still belongs to the case that is ending.
    assign case_err_now = flag_reg | cmp_hit;
    assign last_case    = ({1'b0, count_reg} + 33'd1) == {1'b0, max_reg};
    assign epoch_wrap   = (seq_reg == CW'(TC - 1));
    assign rd_idx       = seq_reg ^ mask;

    always_ff @(posedge clk) begin
        if (wr_en && state_reg != RUN) begin
            mem_a[wr_addr] <= wr_a;
            mem_y[wr_addr] <= wr_y;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = (max_cases != 32'd0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (last_cycle && last_case) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            seq_reg        <= '0;
            cycle_reg      <= '0;
            max_reg        <= '0;
            count_reg      <= '0;
            err_total_reg  <= '0;
            epoch_acc_reg  <= '0;
            epoch_err_reg  <= '0;
            flag_reg       <= 1'b0;
            case_done_reg  <= 1'b0;
            case_err_reg   <= 1'b0;
            epoch_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            case_done_reg  <= 1'b0;
            epoch_done_reg <= 1'b0;
            if (start_go) begin
                seq_reg       <= '0;
                cycle_reg     <= '0;
                max_reg       <= max_cases;
                count_reg     <= '0;
                err_total_reg <= '0;
                epoch_acc_reg <= '0;
                epoch_err_reg <= '0;
                flag_reg      <= 1'b0;
                case_err_reg  <= 1'b0;
            end else if (state_reg == RUN) begin
                if (cmp_hit) begin
                    flag_reg <= 1'b1;
                end
                if (last_cycle) begin
                    cycle_reg     <= '0;
                    seq_reg       <= seq_reg + CW'(1);
                    count_reg     <= sat_inc(count_reg);
                    case_done_reg <= 1'b1;
                    case_err_reg  <= case_err_now;
                    flag_reg      <= 1'b0;
                    if (case_err_now) begin
                        err_total_reg <= sat_inc(err_total_reg);
                    end
                    if (epoch_wrap) begin
                        epoch_done_reg <= 1'b1;
                        epoch_err_reg  <= case_err_now ? sat_inc(epoch_acc_reg) : epoch_acc_reg;
                        epoch_acc_reg  <= '0;
                    end else if (case_err_now) begin
                        epoch_acc_reg <= sat_inc(epoch_acc_reg);
                    end
                end else begin
                    cycle_reg <= cycle_reg + KW'(1);
                end
            end
        end
    end

`ifdef SHUFFLE_EN
    localparam logic [CW-1:0] TAPS = CW'(lfsr_taps(CW));
    logic [CW-1:0] mask_reg;

    // Mask is fixed for a whole epoch, so each epoch is still a permutation of all cases.
    always_ff @(posedge clk) begin
        if (reset || start_go) begin
            mask_reg <= CW'(1);
        end else if (last_cycle && epoch_wrap) begin
            mask_reg <= mask_reg[0] ? ((mask_reg >> 1) ^ TAPS) : (mask_reg >> 1);
        end
    end
    assign mask = mask_reg;
`else
    assign mask = '0;
`endif

    slice_sel #(.W(A_W), .N(NI / A_W), .IDXW(KW)) u_a_sel (
        .vec   (mem_a[rd_idx]),
        .idx   (cycle_reg),
        .en    (state_reg == RUN),
        .slice (a_in)
    );

    slice_sel #(.W(Y_W), .N(NO / Y_W), .IDXW(KW)) u_y_sel (
        .vec   (mem_y[rd_idx]),
        .idx   (cycle_reg),
        .en    (state_reg == RUN),
        .slice (y_in)
    );

    assign running    = (state_reg == RUN);
    assign done       = (state_reg == DONE);
    assign case_idx   = rd_idx;
    assign cycle_idx  = cycle_reg;
    assign case_done  = case_done_reg;
    assign case_err   = case_err_reg;
    assign case_count = count_reg;
    assign err_total  = err_total_reg;
    assign epoch_done = epoch_done_reg;
    assign epoch_err  = epoch_err_reg;

endmodule

// File: tb/tb_dnn_train_sequencer.sv
// Scoreboard bench for dnn_train_sequencer: stimulus queues expectations, a monitor pops them.
module tb_dnn_train_sequencer;

    localparam int NI = 64, NO = 4, A_W = 4, Y_W = 1, TC = 32, CPC = 18, CMP_START = 2;

    typedef struct { int idx; logic [3:0] a1; } idx_e_t;
    typedef struct { logic err; int cnt; int tot; } case_e_t;
    typedef struct { logic [3:0] a; logic y; } slice_e_t;

    logic        clk = 1'b0, reset = 1'b1, wr_en = 1'b0, start = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [63:0] wr_a = '0;
    logic [3:0]  wr_y = '0;
    logic [31:0] max_cases = '0;
    logic [0:0]  a_out, y_out;
    logic [3:0]  a_in;
    logic [0:0]  y_in;
    logic        running, done, case_done, case_err, epoch_done;
    logic [4:0]  case_idx, cycle_idx;
    logic [31:0] case_count, err_total, epoch_err;

    int errors = 0, checks = 0;
    int err_k = -1, e0 = -1, e1 = -1;
    int obs [128];
    int obs_n = 0;

    logic [63:0] mem_a_tb [TC];
    logic [3:0]  mem_y_tb [TC];

    idx_e_t   idx_q[$];
    case_e_t  case_q[$];
    int       epoch_q[$];
    slice_e_t slice_q[$];

    dnn_train_sequencer #(
        .NI(NI), .NO(NO), .A_W(A_W), .Y_W(Y_W), .TC(TC), .CPC(CPC), .CMP_START(CMP_START)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_a(wr_a), .wr_y(wr_y),
        .start(start), .max_cases(max_cases), .a_in(a_in), .y_in(y_in), .a_out(a_out),
        .y_out(y_out), .running(running), .done(done), .case_idx(case_idx),
        .cycle_idx(cycle_idx), .case_done(case_done), .case_err(case_err),
        .case_count(case_count), .err_total(err_total), .epoch_done(epoch_done),
        .epoch_err(epoch_err)
    );

    always #5 clk = ~clk;

    // DNN stand-in: ideal and actual agree except at the injected case/cycle.
    always_comb begin
        y_out = 1'b0;
        a_out = 1'b0;
        if (running && int'(cycle_idx) == err_k &&
            (int'(case_count) == e0 || int'(case_count) == e1))
            a_out = 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got pulse expected none", name);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (running && cycle_idx == 5'd1 && idx_q.size() > 0) begin
                idx_e_t ie;
                ie = idx_q.pop_front();
                if (obs_n < 128) obs[obs_n] = int'(case_idx);
                obs_n++;
                $display("case start: idx=%0d a_in(k1)=%0h", case_idx, a_in);
                check("case_idx", 64'(case_idx), 64'(ie.idx));
                check("a_in_k1", 64'(a_in), 64'(ie.a1));
            end
            if (running && slice_q.size() > 0) begin
                slice_e_t se;
                se = slice_q.pop_front();
                check("a_in_slice", 64'(a_in), 64'(se.a));
                check("y_in_slice", 64'(y_in), 64'(se.y));
            end
            if (case_done) begin
                if (case_q.size() == 0) unexpected("case_done");
                else begin
                    case_e_t ce;
                    ce = case_q.pop_front();
                    $display("case done: count=%0d err=%0b total=%0d", case_count, case_err, err_total);
                    check("case_err", 64'(case_err), 64'(ce.err));
                    check("case_count", 64'(case_count), 64'(ce.cnt));
                    check("err_total", 64'(err_total), 64'(ce.tot));
                end
            end
            if (epoch_done) begin
                if (epoch_q.size() == 0) unexpected("epoch_done");
                else begin
                    int ee;
                    ee = epoch_q.pop_front();
                    $display("epoch done: count=%0d epoch_err=%0d", case_count, epoch_err);
                    check("epoch_err", 64'(epoch_err), 64'(ee));
                end
            end
        end
    end

    task automatic prepare(input int n, input int pe0, input int pe1, input int pk);
        int tot, ep;
        logic [4:0] m;
        logic err;
        idx_e_t ie;
        case_e_t ce;
        tot = 0; ep = 0;
        e0 = pe0; e1 = pe1; err_k = pk; obs_n = 0;
`ifdef SHUFFLE_EN
        m = 5'd1;
`else
        m = 5'd0;
`endif
        for (int i = 0; i < n; i++) begin
            err = (i == pe0 || i == pe1) && pk >= CMP_START && pk < CPC;
            tot += int'(err);
            ep  += int'(err);
            ie.idx = (i % TC) ^ int'(m);
            ie.a1  = mem_a_tb[ie.idx][59:56];
            idx_q.push_back(ie);
            ce.err = err; ce.cnt = i + 1; ce.tot = tot;
            case_q.push_back(ce);
            if ((i + 1) % TC == 0) begin
                epoch_q.push_back(ep);
                ep = 0;
`ifdef SHUFFLE_EN
                m = m[0] ? ((m >> 1) ^ 5'h14) : (m >> 1);
`endif
            end
        end
    endtask

    task automatic push_slices(input int c);
        slice_e_t se;
        for (int k = 0; k < CPC; k++) begin
            se.a = (k < 16) ? mem_a_tb[c][(15-k)*4 +: 4] : 4'h0;
            se.y = (k < 4) ? mem_y_tb[c][3-k] : 1'b0;
            slice_q.push_back(se);
        end
    endtask

    task automatic pulse_start(input int n);
        max_cases = n;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp);
        int c;
        c = 0;
        while (!done && c < exp + 50) begin
            @(posedge clk); #1;
            c++;
        end
        $display("run finished after %0d cycles", c);
        check("done_cycles", 64'(c), 64'(exp));
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < TC; c++) begin
            mem_a_tb[c] = (c == 0) ? 64'hf000_0000_0000_0000 : {8'(c * 3 + 1), 56'h00ff_00ff_1234_56};
            mem_y_tb[c] = (c == 0) ? 4'b1000 : (4'(c) ^ 4'b1010);
        end

        repeat (5) @(posedge clk);
        #1;
        check("rst_running", 64'(running), 0);
        check("rst_done", 64'(done), 0);
        check("rst_a_in", 64'(a_in), 0);
        check("rst_case_count", 64'(case_count), 0);
        check("rst_case_idx", 64'(case_idx), 0);
        reset = 1'b0;

        for (int c = 0; c < TC; c++) begin
            wr_addr = 5'(c); wr_a = mem_a_tb[c]; wr_y = mem_y_tb[c]; wr_en = 1'b1;
            @(posedge clk); #1;
        end
        wr_en = 1'b0;

        // Single clean case with full slice trace.
        prepare(1, -1, -1, -1);
        push_slices(0);
        pulse_start(1);
        wait_done(18);

        // Mismatch in the last cycle counts; before CMP_START it does not.
        prepare(1, 0, -1, 17);
        pulse_start(1);
        wait_done(18);
        prepare(1, 0, -1, 1);
        pulse_start(1);
        wait_done(18);

        // Long run across two epoch boundaries, with a write attempt mid-run.
        prepare(70, 5, 40, 10);
        fork
            begin
                pulse_start(70);
                wait_done(1260);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                wr_addr = 5'd3; wr_a = '1; wr_y = 4'hf; wr_en = 1'b1;
                @(posedge clk); #1;
                wr_en = 1'b0;
            end
        join
`ifdef SHUFFLE_EN
        begin : perm_chk
            bit [31:0] seen;
            bit diff;
            seen = '0; diff = 1'b0;
            for (int i = 32; i < 64; i++) seen[obs[i]] = 1'b1;
            for (int i = 0; i < 32; i++) if (obs[i] != obs[i+32]) diff = 1'b1;
            check("epoch2_perm", 64'($countones(seen)), 32);
            check("epoch2_differs", 64'(diff), 1);
        end
`endif

        // max_cases of zero goes straight to DONE.
        prepare(0, -1, -1, -1);
        pulse_start(0);
        check("zero_done", 64'(done), 1);
        check("zero_count", 64'(case_count), 0);

        // Reset in the middle of a run.
        prepare(70, -1, -1, -1);
        pulse_start(70);
        repeat (500) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        idx_q.delete(); case_q.delete(); epoch_q.delete(); slice_q.delete();
        $display("reset mid-run: running=%0b count=%0d", running, case_count);
        check("mid_rst_running", 64'(running), 0);
        check("mid_rst_done", 64'(done), 0);
        check("mid_rst_count", 64'(case_count), 0);
        check("mid_rst_err_total", 64'(err_total), 0);
        check("mid_rst_cycle_idx", 64'(cycle_idx), 0);
        check("mid_rst_a_in", 64'(a_in), 0);

        // Restart reproduces case 0.
        prepare(1, -1, -1, -1);
        push_slices(0);
        pulse_start(1);
        wait_done(18);

        // Write and start in the same cycle: the run sees the new data.
        mem_a_tb[0] = 64'h5c3a_0000_0000_00f1;
        mem_y_tb[0] = 4'b0110;
        prepare(1, -1, -1, -1);
        push_slices(0);
        wr_addr = 5'd0; wr_a = mem_a_tb[0]; wr_y = mem_y_tb[0]; wr_en = 1'b1;
        max_cases = 1; start = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0; start = 1'b0;
        wait_done(18);

        check("idx_q_drained", 64'(idx_q.size()), 0);
        check("case_q_drained", 64'(case_q.size()), 0);
        check("epoch_q_drained", 64'(epoch_q.size()), 0);
        check("slice_q_drained", 64'(slice_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dnn_train_sequencer.md
Name: dnn_train_sequencer

Overview:
Synthesizable training-data sequencer and scorer for the DNN core. It holds TC training cases (NI-bit activation, NO-bit ideal output) in an internal register file and streams each case into the DNN as per-clock slices over a CPC-cycle block. It compares the DNN outputs each cycle and accumulates per-case, per-epoch and total error counts. It replaces bench-only muxing and scoring, so training can run on silicon or FPGA.

Parameters:
NI, 64, input neurons n[0]
NO, 4, output neurons n[L-1]
A_W, 4, activations fed per clock (z[0]/fo[0]); NI % A_W == 0
Y_W, 1, ideal outputs fed and compared per clock (z[L-2]/fi[L-2]); NO % Y_W == 0
TC, 32, training cases stored; power of two, >=2
CPC, NI/A_W+2, cycles per case block; CPC >= NI/A_W+2 and CPC-2 >= NO/Y_W
CMP_START, 2, first cycle_idx at which outputs are compared

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
wr_en  in  1  case-memory write strobe (honoured in IDLE/DONE only)
wr_addr  in  $clog2(TC)  case index to write
wr_a  in  NI  activation vector
wr_y  in  NO  ideal output vector
start  in  1  begin run (IDLE/DONE only)
max_cases  in  32  number of cases to run
a_in  out  A_W  activation slice to DNN
y_in  out  Y_W  ideal-output slice to DNN
a_out  in  Y_W  DNN actual output
y_out  in  Y_W  DNN ideal output after pipeline
running  out  1  state==RUN
done  out  1  state==DONE
case_idx  out  $clog2(TC)  memory index of current case
cycle_idx  out  $clog2(CPC)  position in case block
case_done  out  1  one-cycle pulse, case finished
case_err  out  1  error flag of last finished case
case_count  out  32  cases finished this run
err_total  out  32  erroneous cases this run
epoch_done  out  1  one-cycle pulse after every TC-th case
epoch_err  out  32  erroneous cases in last completed epoch

Behaviour:
- Reset: state IDLE. All outputs and counters are 0. Case memory is not reset.
- FSM:
  - IDLE: start & max_cases!=0 -> RUN; start & max_cases==0 -> DONE. Counters clear on start.
  - RUN: at the end of cycle_idx==CPC-1 with case_count+1==max_cases -> DONE.
  - DONE: start behaves as in IDLE.
- The block latches max_cases at start.
- RUN, cycle k = cycle_idx:
  - a_in = slice (NI/A_W-1-k) of the case activation (MSB slice first) for k < NI/A_W, else 0.
  - y_in = slice (NO/Y_W-1-k) of the case ideal output for k < NO/Y_W, else 0.
  - Outputs are combinational from registered cycle_idx/case_idx and asynchronous memory read.
  - In IDLE/DONE, a_in = y_in = 0.
- Compare: in RUN with k >= CMP_START, a_out != y_out sets the internal mismatch flag. A mismatch in cycle CPC-1 counts toward the current case.
- Case end (edge after k==CPC-1):
  - cycle_idx -> 0; case_idx +1 mod TC; case_count +1.
  - case_done pulses the next cycle.
  - case_err <= flag; err_total += flag; flag clears.
  - When case_idx wraps TC-1 -> 0: epoch_done pulses, epoch_err <= epoch accumulator including this case, accumulator clears.
- Counters saturate at 2^32-1.
- wr_en in RUN is ignored; memory is unchanged. A write and start in the same cycle: the write takes effect, and the run sees the new data.
- start during RUN is ignored.
- reset mid-RUN: IDLE next cycle, everything cleared except memory.

Optional Feature:
SHUFFLE_EN:
- Defined: the case index sequence is seq ^ mask. seq is the sequential counter; mask is a $clog2(TC)-bit maximal LFSR (nonzero seed 1 at reset/start), advanced at each epoch end. Every epoch visits each case exactly once. The case_idx port reports the XORed index.
- Undefined: mask is 0 (pure sequential order).

Decomposition:
- Package dnn_train_pkg: state enum (IDLE, RUN, DONE), LFSR tap constants per width, sat_inc function.
- Sub-module: slice_sel (parametrised width/N, MSB-first slice select with out-of-range -> 0), instantiated for a_in and y_in.

Test Plan:
- Reset held 5 cycles -> all outputs 0, running=0, done=0.
- Case 0: a=64'hf000000000000000, y=4'b1000; max_cases=1; a_out tied to y_out -> a_in=4'hf at k=0 and 0 for k=1..17; y_in=1,0,0,0 at k=0..3; done after 18 cycles; case_count=1, err_total=0.
- Single mismatch at k=17 -> case_err=1, err_total=1. Single mismatch at k=1 -> err_total=0.
- max_cases=70, mismatch in cases 5 and 40 -> epoch_done at case_count 32 and 64; epoch_err=1 then 1; err_total=2; done after 1260 cycles.
- reset at RUN cycle 500 -> IDLE next cycle, counters 0. Restart reproduces case 0 data.
- wr_en to case 3 during RUN -> ignored. With SHUFFLE_EN: epoch-2 case_idx sequence is a permutation of 0..31, differing from epoch 1.
